// File: rtl/param_rs.sv
// param_rs -- age-ordered reservation station for the ALU issue path.
//
// Holds up to DEPTH dispatched ops, snoops NUM_CDB result buses to resolve
// source tags, and hands the oldest fully-ready entry to the ALU through a
// registered valid/ready issue slot.
//
// Ports
//   clk_in, rst_n_in        clock, synchronous active-low reset
//   flush_in                drop every entry and empty the issue slot
//   disp_*                  dispatch handshake and op fields (tag 0 = value present)
//   cdb_valid/tag/data_in   packed wakeup buses, port p at [p*W +: W]
//   iss_*                   issue slot towards the ALU (valid/ready)
//   occupancy_out           entries held, not counting the issue slot
//
// Build option
//   RS_DISPATCH_BYPASS_EN   when defined, an op dispatched during a matching CDB
//                           broadcast captures that data instead of waiting.

module param_rs_wake #(
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int NUM_CDB = 2
) (
    input  logic [TAG_W-1:0]          tag_i,
    input  logic [DATA_W-1:0]         val_i,
    input  logic [NUM_CDB-1:0]        cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_i,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data_i,
    output logic [TAG_W-1:0]          tag_o,
    output logic [DATA_W-1:0]         val_o
);
    // Scan high to low so the lowest matching port is the last writer.
    always_comb begin
        tag_o = tag_i;
        val_o = val_i;
        if (tag_i != '0) begin
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (cdb_valid_i[p] && (cdb_tag_i[p*TAG_W +: TAG_W] == tag_i)) begin
                    tag_o = '0;
                    val_o = cdb_data_i[p*DATA_W +: DATA_W];
                end
            end
        end
    end
endmodule

module param_rs #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int PC_W    = 32,
    parameter int NUM_CDB = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          flush_in,
    input  logic                          disp_valid_in,
    output logic                          disp_ready_out,
    input  logic [OP_W-1:0]               disp_op_in,
    input  logic [TAG_W-1:0]              disp_qj_in,
    input  logic [TAG_W-1:0]              disp_qk_in,
    input  logic [DATA_W-1:0]             disp_vj_in,
    input  logic [DATA_W-1:0]             disp_vk_in,
    input  logic [DATA_W-1:0]             disp_imm_in,
    input  logic [TAG_W-1:0]              disp_dest_in,
    input  logic [PC_W-1:0]               disp_pc_in,
    input  logic [NUM_CDB-1:0]            cdb_valid_in,
    input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag_in,
    input  logic [NUM_CDB*DATA_W-1:0]     cdb_data_in,
    output logic                          iss_valid_out,
    input  logic                          iss_ready_in,
    output logic [OP_W-1:0]               iss_op_out,
    output logic [DATA_W-1:0]             iss_vj_out,
    output logic [DATA_W-1:0]             iss_vk_out,
    output logic [DATA_W-1:0]             iss_imm_out,
    output logic [TAG_W-1:0]              iss_dest_out,
    output logic [PC_W-1:0]               iss_pc_out,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy_out
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0][OP_W-1:0]    op_q, op_d;
    logic [DEPTH-1:0][TAG_W-1:0]   qj_q, qj_d, qj_w, qk_q, qk_d, qk_w;
    logic [DEPTH-1:0][DATA_W-1:0]  vj_q, vj_d, vj_w, vk_q, vk_d, vk_w;
    logic [DEPTH-1:0][DATA_W-1:0]  imm_q, imm_d;
    logic [DEPTH-1:0][TAG_W-1:0]   dest_q, dest_d;
    logic [DEPTH-1:0][PC_W-1:0]    pc_q, pc_d;
    // older_q[a][b] = 1: entry a was dispatched before entry b.
    logic [DEPTH-1:0][DEPTH-1:0]   older_q, older_d;
    logic [OCC_W-1:0]              occ_q, occ_d;

    logic                          iss_valid_q, iss_valid_d;
    logic [OP_W-1:0]               iss_op_q, iss_op_d;
    logic [DATA_W-1:0]             iss_vj_q, iss_vj_d, iss_vk_q, iss_vk_d;
    logic [DATA_W-1:0]             iss_imm_q, iss_imm_d;
    logic [TAG_W-1:0]              iss_dest_q, iss_dest_d;
    logic [PC_W-1:0]               iss_pc_q, iss_pc_d;

    logic [DEPTH-1:0]              cand, sel_oh;
    logic [IDX_W-1:0]              sel_idx, free_idx;
    logic                          any_cand, iss_load, iss_fire, disp_fire;
    logic [TAG_W-1:0]              disp_qj_eff, disp_qk_eff;
    logic [DATA_W-1:0]             disp_vj_eff, disp_vk_eff;

    // Per-entry operand wakeup.
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        param_rs_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) u_wj (
            .tag_i(qj_q[e]), .val_i(vj_q[e]), .cdb_valid_i(cdb_valid_in),
            .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
            .tag_o(qj_w[e]), .val_o(vj_w[e]));
        param_rs_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) u_wk (
            .tag_i(qk_q[e]), .val_i(vk_q[e]), .cdb_valid_i(cdb_valid_in),
            .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
            .tag_o(qk_w[e]), .val_o(vk_w[e]));
    end

`ifdef RS_DISPATCH_BYPASS_EN
    // Catch a broadcast that coincides with dispatch.
    param_rs_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) u_bj (
        .tag_i(disp_qj_in), .val_i(disp_vj_in), .cdb_valid_i(cdb_valid_in),
        .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
        .tag_o(disp_qj_eff), .val_o(disp_vj_eff));
    param_rs_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) u_bk (
        .tag_i(disp_qk_in), .val_i(disp_vk_in), .cdb_valid_i(cdb_valid_in),
        .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
        .tag_o(disp_qk_eff), .val_o(disp_vk_eff));
`else
    assign disp_qj_eff = disp_qj_in;
    assign disp_vj_eff = disp_vj_in;
    assign disp_qk_eff = disp_qk_in;
    assign disp_vk_eff = disp_vk_in;
`endif

    // Ready never credits an entry freed on the same edge.
    assign disp_ready_out = (occ_q != OCC_W'(DEPTH));
    assign disp_fire      = disp_valid_in && disp_ready_out;

    // Select only from registered tags, so a wakeup is visible one cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
    end

    // An entry wins when no other candidate is older than it.
    always_comb begin
        sel_oh  = cand;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && cand[j] && older_q[j][i]) sel_oh[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    assign any_cand = |cand;
    assign iss_load = !iss_valid_q || iss_ready_in;
    assign iss_fire = iss_load && any_cand;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        qj_d    = qj_w;
        vj_d    = vj_w;
        qk_d    = qk_w;
        vk_d    = vk_w;
        imm_d   = imm_q;
        dest_d  = dest_q;
        pc_d    = pc_q;
        older_d = older_q;
        if (iss_fire) valid_d[sel_idx] = 1'b0;
        if (disp_fire) begin
            valid_d[free_idx] = 1'b1;
            op_d[free_idx]    = disp_op_in;
            qj_d[free_idx]    = disp_qj_eff;
            vj_d[free_idx]    = disp_vj_eff;
            qk_d[free_idx]    = disp_qk_eff;
            vk_d[free_idx]    = disp_vk_eff;
            imm_d[free_idx]   = disp_imm_in;
            dest_d[free_idx]  = disp_dest_in;
            pc_d[free_idx]    = disp_pc_in;
            // Newcomer is younger than everything else currently held.
            for (int j = 0; j < DEPTH; j++) begin
                older_d[j][free_idx] = 1'b1;
                older_d[free_idx][j] = 1'b0;
            end
        end
        occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(iss_fire);
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_op_d    = iss_op_q;
        iss_vj_d    = iss_vj_q;
        iss_vk_d    = iss_vk_q;
        iss_imm_d   = iss_imm_q;
        iss_dest_d  = iss_dest_q;
        iss_pc_d    = iss_pc_q;
        if (iss_load) begin
            iss_valid_d = any_cand;
            if (any_cand) begin
                iss_op_d   = op_q[sel_idx];
                iss_vj_d   = vj_q[sel_idx];
                iss_vk_d   = vk_q[sel_idx];
                iss_imm_d  = imm_q[sel_idx];
                iss_dest_d = dest_q[sel_idx];
                iss_pc_d   = pc_q[sel_idx];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || flush_in) begin
            valid_q     <= '0;
            op_q        <= '0;
            qj_q        <= '0;
            vj_q        <= '0;
            qk_q        <= '0;
            vk_q        <= '0;
            imm_q       <= '0;
            dest_q      <= '0;
            pc_q        <= '0;
            older_q     <= '0;
            occ_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_vj_q    <= '0;
            iss_vk_q    <= '0;
            iss_imm_q   <= '0;
            iss_dest_q  <= '0;
            iss_pc_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            op_q        <= op_d;
            qj_q        <= qj_d;
            vj_q        <= vj_d;
            qk_q        <= qk_d;
            vk_q        <= vk_d;
            imm_q       <= imm_d;
            dest_q      <= dest_d;
            pc_q        <= pc_d;
            older_q     <= older_d;
            occ_q       <= occ_d;
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_vj_q    <= iss_vj_d;
            iss_vk_q    <= iss_vk_d;
            iss_imm_q   <= iss_imm_d;
            iss_dest_q  <= iss_dest_d;
            iss_pc_q    <= iss_pc_d;
        end
    end

    assign iss_valid_out = iss_valid_q;
    assign iss_op_out    = iss_op_q;
    assign iss_vj_out    = iss_vj_q;
    assign iss_vk_out    = iss_vk_q;
    assign iss_imm_out   = iss_imm_q;
    assign iss_dest_out  = iss_dest_q;
    assign iss_pc_out    = iss_pc_q;
    assign occupancy_out = occ_q;
endmodule

// File: tb/tb_param_rs.sv
// Directed bench for param_rs (default parameters).
module tb_param_rs;
    logic        clk = 1'b0;
    logic        rst_n, flush, disp_valid, disp_ready, iss_valid, iss_ready;
    logic [5:0]  disp_op, iss_op;
    logic [3:0]  disp_qj, disp_qk, disp_dest, iss_dest, occ;
    logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc;
    logic [31:0] iss_vj, iss_vk, iss_imm, iss_pc;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    int          checks = 0;
    int          failures = 0;

    param_rs dut (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
        .disp_valid_in(disp_valid), .disp_ready_out(disp_ready),
        .disp_op_in(disp_op), .disp_qj_in(disp_qj), .disp_qk_in(disp_qk),
        .disp_vj_in(disp_vj), .disp_vk_in(disp_vk), .disp_imm_in(disp_imm),
        .disp_dest_in(disp_dest), .disp_pc_in(disp_pc),
        .cdb_valid_in(cdb_valid), .cdb_tag_in(cdb_tag), .cdb_data_in(cdb_data),
        .iss_valid_out(iss_valid), .iss_ready_in(iss_ready),
        .iss_op_out(iss_op), .iss_vj_out(iss_vj), .iss_vk_out(iss_vk),
        .iss_imm_out(iss_imm), .iss_dest_out(iss_dest), .iss_pc_out(iss_pc),
        .occupancy_out(occ));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        disp_valid = 1'b0; flush = 1'b0;
        disp_op = '0; disp_qj = '0; disp_qk = '0; disp_vj = '0; disp_vk = '0;
        disp_imm = '0; disp_dest = '0; disp_pc = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                            input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] dest);
        disp_valid = 1'b1; disp_op = op; disp_qj = qj; disp_qk = qk;
        disp_vj = vj; disp_vk = vk; disp_dest = dest;
        disp_imm = 32'h1000 + 32'(op); disp_pc = 32'h400 + 32'(op) * 4;
    endtask

    task automatic test_reset;
        idle(); iss_ready = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid got %0h exp 0", iss_valid); end
        checks++; if (occ !== 4'd0) begin failures++; $display("FAIL reset_occ got %0d exp 0", occ); end
        checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got %0h exp 1", disp_ready); end
        checks++; if (iss_op !== 6'h0 || iss_vj !== 32'h0 || iss_pc !== 32'h0) begin failures++; $display("FAIL reset_iss_data got op=%0h vj=%0h pc=%0h exp 0", iss_op, iss_vj, iss_pc); end
    endtask

    task automatic test_wakeup;
        iss_ready = 1'b1;
        set_disp(6'h01, 4'd3, 4'd0, 32'h0, 32'h10, 4'd1);        // A waits on tag 3
        tick();
        set_disp(6'h02, 4'd0, 4'd0, 32'hB1, 32'hB2, 4'd2);       // B ready
        tick();
        idle();
        checks++; if (iss_valid !== 1'b0 || occ !== 4'd2) begin failures++; $display("FAIL wake_wait got valid=%0h occ=%0d exp 0/2", iss_valid, occ); end
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_data = {32'h0, 32'h55};
        tick();
        idle();
        checks++; if (iss_valid !== 1'b1 || iss_op !== 6'h02 || iss_vj !== 32'hB1 || iss_dest !== 4'd2) begin failures++; $display("FAIL wake_B_first got v=%0h op=%0h vj=%0h dest=%0h exp 1/02/b1/2", iss_valid, iss_op, iss_vj, iss_dest); end
        checks++; if (occ !== 4'd1) begin failures++; $display("FAIL wake_occ1 got %0d exp 1", occ); end
        tick();
        checks++; if (iss_valid !== 1'b1 || iss_op !== 6'h01 || iss_vj !== 32'h55 || iss_vk !== 32'h10 || iss_imm !== 32'h1001 || iss_pc !== 32'h404) begin failures++; $display("FAIL wake_A_second got v=%0h op=%0h vj=%0h vk=%0h imm=%0h pc=%0h", iss_valid, iss_op, iss_vj, iss_vk, iss_imm, iss_pc); end
        tick();
        checks++; if (iss_valid !== 1'b0 || occ !== 4'd0) begin failures++; $display("FAIL wake_drain got valid=%0h occ=%0d exp 0/0", iss_valid, occ); end
    endtask

    task automatic test_fill;
        logic [5:0] eop;
        iss_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            set_disp(6'(16 + k), 4'd0, 4'd0, 32'(k), 32'(100 + k), 4'(k + 1));
            tick();
            if (k == 1) begin
                checks++; if (occ !== 4'd1) begin failures++; $display("FAIL fill_disp_plus_issue_occ got %0d exp 1", occ); end
            end
        end
        checks++; if (occ !== 4'd8 || disp_ready !== 1'b0) begin failures++; $display("FAIL fill_full got occ=%0d ready=%0h exp 8/0", occ, disp_ready); end
        set_disp(6'h3F, 4'd0, 4'd0, 32'h0, 32'h0, 4'd15);      // 10th offer, must be refused
        tick();
        idle();
        checks++; if (occ !== 4'd8 || iss_valid !== 1'b1 || iss_op !== 6'h10) begin failures++; $display("FAIL fill_refuse_stall got occ=%0d v=%0h op=%0h exp 8/1/10", occ, iss_valid, iss_op); end
        iss_ready = 1'b1;
        for (int k = 1; k < 9; k++) begin
            tick();
            eop = 6'(16 + k);
            checks++; if (iss_valid !== 1'b1 || iss_op !== eop || iss_vj !== 32'(k)) begin failures++; $display("FAIL fill_order_%0d got v=%0h op=%0h vj=%0h exp 1/%0h/%0h", k, iss_valid, iss_op, iss_vj, eop, k); end
        end
        tick();
        checks++; if (iss_valid !== 1'b0 || occ !== 4'd0) begin failures++; $display("FAIL fill_drain got v=%0h occ=%0d exp 0/0", iss_valid, occ); end
    endtask

    task automatic test_multi_cdb;
        iss_ready = 1'b1;
        set_disp(6'h21, 4'd0, 4'd5, 32'h7, 32'h0, 4'd3);
        tick();
        idle();
        cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd5}; cdb_data = {32'h22, 32'h11};
        tick();
        idle();
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL multi_not_early got %0h exp 0", iss_valid); end
        tick();
        checks++; if (iss_valid !== 1'b1 || iss_op !== 6'h21 || iss_vk !== 32'h11 || iss_vj !== 32'h7) begin failures++; $display("FAIL multi_low_port got v=%0h op=%0h vk=%0h vj=%0h exp 1/21/11/7", iss_valid, iss_op, iss_vk, iss_vj); end
        tick();
    endtask

    task automatic test_flush;
        iss_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_disp(6'(40 + k), 4'd0, 4'd0, 32'h1, 32'h2, 4'd9);
            tick();
        end
        idle();
        checks++; if (occ !== 4'd4 || iss_valid !== 1'b1) begin failures++; $display("FAIL flush_pre got occ=%0d v=%0h exp 4/1", occ, iss_valid); end
        flush = 1'b1;
        set_disp(6'h2F, 4'd0, 4'd0, 32'h0, 32'h0, 4'd1);        // dispatch overridden by flush
        tick();
        idle();
        checks++; if (occ !== 4'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1 || iss_op !== 6'h0) begin failures++; $display("FAIL flush_clear got occ=%0d v=%0h rdy=%0h op=%0h exp 0/0/1/0", occ, iss_valid, disp_ready, iss_op); end
        iss_ready = 1'b1;
        tick(); tick();
        checks++; if (iss_valid !== 1'b0 || occ !== 4'd0) begin failures++; $display("FAIL flush_stays_empty got v=%0h occ=%0d exp 0/0", iss_valid, occ); end
    endtask

    task automatic test_bypass;
        iss_ready = 1'b1;
        set_disp(6'h30, 4'd0, 4'd7, 32'h1, 32'h0, 4'd4);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd7}; cdb_data = {32'h0, 32'h9};
        tick();
        idle();
        tick();
`ifdef RS_DISPATCH_BYPASS_EN
        checks++; if (iss_valid !== 1'b1 || iss_op !== 6'h30 || iss_vk !== 32'h9) begin failures++; $display("FAIL bypass_issue got v=%0h op=%0h vk=%0h exp 1/30/9", iss_valid, iss_op, iss_vk); end
        tick();
`else
        tick(); tick();
        checks++; if (iss_valid !== 1'b0 || occ !== 4'd1) begin failures++; $display("FAIL nobypass_wait got v=%0h occ=%0d exp 0/1", iss_valid, occ); end
        cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd0}; cdb_data = {32'h9, 32'h0};
        tick();
        idle();
        tick();
        checks++; if (iss_valid !== 1'b1 || iss_op !== 6'h30 || iss_vk !== 32'h9) begin failures++; $display("FAIL nobypass_rebroadcast got v=%0h op=%0h vk=%0h exp 1/30/9", iss_valid, iss_op, iss_vk); end
        tick();
`endif
        checks++; if (iss_valid !== 1'b0 || occ !== 4'd0) begin failures++; $display("FAIL bypass_drain got v=%0h occ=%0d exp 0/0", iss_valid, occ); end
    endtask

    initial begin
        idle(); rst_n = 1'b0; iss_ready = 1'b0;
        test_reset();
        test_wakeup();
        test_fill();
        test_multi_cdb();
        test_flush();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
